avgpool_feeder: RTL and testbench
=================================

// Module: avgpool_feeder
// PURPOSE
//  Sequencer that drives the global-average-pool unit (average) channel by channel.
//  - Reads each channel's feature map from activation memory.
//  - Packs it into LANES-wide words and masks the unused lanes of the final partial word.
//  - Strobes the words into the average unit, then writes the returned 10-bit mean
//    to the result memory.
//  - Sits between the last pointwise layer's output buffer and the FC/classifier input buffer.
// PARAMETERS
//  LANES     9      activations per memory word / per average-unit write
//  DW        10     bits per activation
//  PIXELS    4096   activations per channel (64x64)
//  CHANNELS  1024   channels processed per i_start
//  AVG_LAT   2      cycles from the last o_writeAdd to a valid i_avgData
//  AW        20     activation memory address width
//  CW        10     result address width (>= clog2(CHANNELS))
// PORTS
//  i_clk       in   1         clock, all logic on rising edge
//  i_reset     in   1         asynchronous, active-low reset
//  i_start     in   1         1-cycle pulse: process all channels (ignored while o_busy)
//  o_busy      out  1         high from the cycle after i_start until the o_done cycle
//  o_done      out  1         1-cycle pulse after the last result write
//  o_rdEn      out  1         activation memory read enable
//  o_rdAddr    out  AW        activation memory word address
//  i_rdData    in   LANES*DW  read data, valid exactly 1 cycle after o_rdEn
//  o_avgClr    out  1         active-low clear to the average unit's i_reset
//  o_writeAdd  out  1         accumulate strobe to the average unit
//  o_data      out  LANES*DW  packed, masked word to the average unit
//  i_avgData   in   DW        mean from the average unit
//  o_resWe     out  1         result memory write enable (1 cycle)
//  o_resAddr   out  CW        result address = channel index
//  o_resData   out  DW        result data
// BEHAVIOUR
//  Reset (i_reset=0, any time, async)
//   - All outputs 0 except o_avgClr=1.
//   - FSM returns to IDLE; channel and word counters clear.
//   - Reset mid-run abandons the run; no result write or o_done is produced.
//  Layout and masking
//   - WPC = ceil(PIXELS/LANES) words per channel (456 at defaults).
//   - Channel c, word w is at address c*WPC + w.
//   - Pixel p = w*LANES + k sits in lane k at bits [(LANES-k)*DW-1 -: DW]; lane 0 is the MSB lane.
//   - VL = PIXELS - (WPC-1)*LANES valid lanes in the last word (1 at defaults).
//   - In the last word, lanes k >= VL are forced to 0 in o_data. All other words pass unmodified.
//  FSM
//   - IDLE: on i_start go to CLR.
//   - CLR (1 cycle): o_avgClr=0; go to FEED.
//   - FEED (WPC cycles): o_rdEn=1, o_rdAddr=c*WPC+w, w increments 0..WPC-1.
//     - Read issued at cycle t -> o_data and o_writeAdd registered, valid at cycle t+2 for one cycle.
//     - This gives exactly WPC back-to-back o_writeAdd pulses per channel, with no gaps.
//   - After w=WPC-1 go to DRAIN.
//   - DRAIN (2+AVG_LAT cycles): covers the pipeline plus average-unit latency; o_writeAdd ends
//     2 cycles into DRAIN.
//   - STORE (1 cycle): o_resWe=1, o_resAddr=c, o_resData=i_avgData.
//     - If c = CHANNELS-1, go to DONE; otherwise c++ and go to CLR.
//   - DONE (1 cycle): o_done=1, o_busy=0; go to IDLE.
//  Rules
//   - Cycles per channel = 1 + WPC + 2 + AVG_LAT + 1 (462 at defaults).
//   - o_writeAdd is never high during CLR, and o_avgClr is never low while writes are in flight.
//   - i_start while busy: no effect, no restart.
//   - i_start in the DONE cycle: ignored.
//   - Address arithmetic must not wrap: CHANNELS*WPC <= 2**AW (static assertion).
// TESTING
//  1. CHANNELS=1, every lane = 8 -> 456 o_writeAdd pulses; last word = {10'd8,80'd0};
//     o_resWe with addr 0, data 8.
//  2. CHANNELS=1, lane0=255, other lanes=200 -> last word masked to {10'd255,80'd0};
//     behavioural average model returns 206; written data 206.
//  3. Last memory word filled with 10'h3FF in all lanes -> o_data lanes 1..8 = 0, lane 0 = 10'h3FF.
//  4. CHANNELS=3, channel c lanes = c+1 -> read addresses 0..1367 contiguous; o_avgClr low once
//     per channel; results (0,1),(1,2),(2,3); one o_done pulse; total 3*462+1 cycles.
//  5. i_reset low mid-FEED of channel 1 -> all outputs 0 and o_avgClr=1 immediately; no o_resWe;
//     a new i_start reruns from channel 0 correctly.
//  6. i_start pulsed during FEED and during DONE -> ignored; read sequence and result count unchanged.

Source files
------------

// File: rtl/avgpool_feeder.sv
// avgpool_feeder
//   Sequencer for the global-average-pool unit. For every channel it clears the
//   average unit, streams the channel's feature map out of activation memory as
//   LANES-wide words (lanes past the end of the map in the final word are zeroed),
//   waits for the mean to come back and writes it to the result memory at the
//   channel index. One i_start processes all CHANNELS channels.
//
//   Ports
//     i_clk, i_reset   clock (rising edge), asynchronous active-low reset
//     i_start          1-cycle run request, honoured only in IDLE
//     o_busy, o_done   run in progress / 1-cycle completion pulse
//     o_rdEn, o_rdAddr activation memory read port; i_rdData returns 1 cycle later
//     o_avgClr         active-low clear to the average unit
//     o_writeAdd       accumulate strobe, o_data is the packed masked word
//     i_avgData        mean returned by the average unit
//     o_resWe, o_resAddr, o_resData   result memory write port
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for i_start
//   S_CLR   | 1 cycle, average unit held in clear
//   S_FEED  | WPC cycles, one activation word read per cycle
//   S_DRAIN | 2+AVG_LAT cycles, read pipeline and average unit settle
//   S_STORE | 1 cycle, mean written to result memory
//   S_DONE  | 1 cycle, o_done pulse
module avgpool_feeder #(
    parameter int LANES    = 9,
    parameter int DW       = 10,
    parameter int PIXELS   = 4096,
    parameter int CHANNELS = 1024,
    parameter int AVG_LAT  = 2,
    parameter int AW       = 20,
    parameter int CW       = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rdEn,
    output logic [AW-1:0]         o_rdAddr,
    input  logic [LANES*DW-1:0]   i_rdData,
    output logic                  o_avgClr,
    output logic                  o_writeAdd,
    output logic [LANES*DW-1:0]   o_data,
    input  logic [DW-1:0]         i_avgData,
    output logic                  o_resWe,
    output logic [CW-1:0]         o_resAddr,
    output logic [DW-1:0]         o_resData
);

    localparam int WPC       = (PIXELS + LANES - 1) / LANES;
    localparam int VL        = PIXELS - (WPC - 1) * LANES;
    localparam int DRAIN_CYC = 2 + AVG_LAT;
    localparam int WW        = $clog2(WPC + 1);
    localparam int DCW       = $clog2(DRAIN_CYC + 1);

    // Lanes 0..VL-1 survive in the final word of a channel; lane 0 is the MSB lane.
    function automatic logic [LANES*DW-1:0] last_mask();
        logic [LANES*DW-1:0] m;
        m = '0;
        for (int k = 0; k < VL; k++) begin
            m[(LANES-k)*DW-1 -: DW] = '1;
        end
        return m;
    endfunction

    localparam logic [LANES*DW-1:0] LAST_MASK = last_mask();

    if (longint'(CHANNELS) * longint'(WPC) > (longint'(1) << AW)) begin : g_addr_chk
        $error("avgpool_feeder: CHANNELS*WPC does not fit in AW address bits");
    end
    if ((longint'(1) << CW) < longint'(CHANNELS)) begin : g_cw_chk
        $error("avgpool_feeder: CW too narrow for CHANNELS");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [WW-1:0]   w_q;
    logic [DCW-1:0]  d_q;
    logic [CW-1:0]   ch_q;
    logic            rd_pend_q;
    logic            last_pend_q;
    logic            last_word;
    logic            last_ch;

    assign last_word = (w_q == WW'(WPC - 1));
    assign last_ch   = (ch_q == CW'(CHANNELS - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        o_rdEn    = 1'b0;
        o_rdAddr  = '0;
        o_avgClr  = 1'b1;
        o_resWe   = 1'b0;
        o_resAddr = '0;
        o_resData = '0;
        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_CLR;
            end
            S_CLR: begin
                o_busy   = 1'b1;
                o_avgClr = 1'b0;
                state_d  = S_FEED;
            end
            S_FEED: begin
                o_busy   = 1'b1;
                o_rdEn   = 1'b1;
                o_rdAddr = addr_q;
                if (last_word) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (d_q == DCW'(DRAIN_CYC - 1)) state_d = S_STORE;
            end
            S_STORE: begin
                o_busy    = 1'b1;
                o_resWe   = 1'b1;
                o_resAddr = ch_q;
                o_resData = i_avgData;
                state_d   = last_ch ? S_DONE : S_CLR;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // addr_q runs continuously across channels, so it always equals ch*WPC + w.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr_q <= '0;
            w_q    <= '0;
            d_q    <= '0;
            ch_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        addr_q <= '0;
                        ch_q   <= '0;
                    end
                end
                S_CLR: begin
                    w_q <= '0;
                    d_q <= '0;
                end
                S_FEED: begin
                    addr_q <= addr_q + 1'b1;
                    w_q    <= w_q + 1'b1;
                end
                S_DRAIN: begin
                    d_q <= d_q + 1'b1;
                end
                S_STORE: begin
                    if (!last_ch) ch_q <= ch_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Two-stage read pipeline: request -> memory data -> registered strobe/word.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_pend_q   <= 1'b0;
            last_pend_q <= 1'b0;
            o_writeAdd  <= 1'b0;
            o_data      <= '0;
        end else begin
            rd_pend_q   <= (state_q == S_FEED);
            last_pend_q <= (state_q == S_FEED) && last_word;
            o_writeAdd  <= rd_pend_q;
            if (!rd_pend_q) begin
                o_data <= '0;
            end else if (last_pend_q) begin
                o_data <= i_rdData & LAST_MASK;
            end else begin
                o_data <= i_rdData;
            end
        end
    end

endmodule

// File: tb/tb_avgpool_feeder.sv
// Bench for avgpool_feeder: activation memory and average unit are behavioural
// stubs; a timeline model derived from the per-channel cycle budget predicts
// every output each cycle, and literal checks pin the model and key results.
module tb_avgpool_feeder;

    localparam int LANES  = 9;
    localparam int DW     = 10;
    localparam int PIXELS = 4096;
    localparam int CH     = 3;
    localparam int AW     = 20;
    localparam int CW     = 10;
    localparam int WPC    = (PIXELS + LANES - 1) / LANES;
    localparam int CPC    = 1 + WPC + 2 + 2 + 1;
    localparam int BW     = LANES * DW;

    logic           i_clk = 1'b0;
    logic           i_reset = 1'b0;
    logic           i_start = 1'b0;
    logic           o_busy, o_done, o_rdEn, o_avgClr, o_writeAdd, o_resWe;
    logic [AW-1:0]  o_rdAddr;
    logic [BW-1:0]  i_rdData = '0;
    logic [BW-1:0]  o_data;
    logic [DW-1:0]  i_avgData = '0;
    logic [CW-1:0]  o_resAddr;
    logic [DW-1:0]  o_resData;

    avgpool_feeder #(
        .LANES(LANES), .DW(DW), .PIXELS(PIXELS), .CHANNELS(CH),
        .AVG_LAT(2), .AW(AW), .CW(CW)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_rdEn(o_rdEn), .o_rdAddr(o_rdAddr),
        .i_rdData(i_rdData), .o_avgClr(o_avgClr), .o_writeAdd(o_writeAdd),
        .o_data(o_data), .i_avgData(i_avgData), .o_resWe(o_resWe),
        .o_resAddr(o_resAddr), .o_resData(o_resData)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int mode  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Pixel value of channel ch, word w, lane k for each memory pattern.
    function automatic logic [DW-1:0] pix(input int md, input int ch, input int w, input int k);
        case (md)
            0:       return 10'd8;
            1:       return (k == 0) ? 10'd255 : 10'd200;
            2:       return DW'(ch + 1);
            default: return (w == WPC - 1) ? 10'h3FF : 10'd100;
        endcase
    endfunction

    function automatic logic [BW-1:0] mem_word(input int md, input int addr);
        logic [BW-1:0] r;
        for (int k = 0; k < LANES; k++) r[(LANES-k)*DW-1 -: DW] = pix(md, addr / WPC, addr % WPC, k);
        return r;
    endfunction

    function automatic logic [BW-1:0] exp_word(input int md, input int ch, input int w);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++)
            if (w * LANES + k < PIXELS) r[(LANES-k)*DW-1 -: DW] = pix(md, ch, w, k);
        return r;
    endfunction

    function automatic int exp_mean(input int md, input int ch);
        longint s;
        s = 0;
        for (int p = 0; p < PIXELS; p++) s += longint'(pix(md, ch, p / LANES, p % LANES));
        return int'(s / PIXELS);
    endfunction

    function automatic longint lane_sum(input logic [BW-1:0] d);
        longint s;
        s = 0;
        for (int k = 0; k < LANES; k++) s += longint'(d[(LANES-k)*DW-1 -: DW]);
        return s;
    endfunction

    // Activation memory: one-cycle read latency.
    always @(posedge i_clk) if (o_rdEn) i_rdData <= mem_word(mode, int'(o_rdAddr));

    // Average unit: accumulate, mean valid 2 cycles after the last strobe.
    longint acc = 0;
    always @(posedge i_clk) begin
        if (!o_avgClr) acc <= 0;
        else if (o_writeAdd) acc <= acc + lane_sum(o_data);
        i_avgData <= DW'(acc / PIXELS);
    end

    // Timeline model: rel counts cycles since the accepted i_start.
    bit active = 0;
    int rel = 0;
    always @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            active <= 0;
            rel    <= 0;
        end else if (active) begin
            if (rel == CH * CPC) active <= 0;
            else rel <= rel + 1;
        end else if (i_start) begin
            active <= 1;
            rel    <= 0;
        end
    end

    int wa_cnt, rd_cnt, clr_cnt, res_cnt, done_cnt, busy_cyc, rd_first, rd_last;
    logic [BW-1:0] last_wdata;
    logic [CW-1:0] res_addr [8];
    logic [DW-1:0] res_data [8];

    task automatic clear_stats();
        wa_cnt = 0; rd_cnt = 0; clr_cnt = 0; res_cnt = 0; done_cnt = 0; busy_cyc = 0;
        rd_first = -1; rd_last = -1; last_wdata = '0;
    endtask

    always @(negedge i_clk) begin
        bit e_busy, e_done, e_clr, e_rden, e_wa, e_we;
        int c, off;
        if (o_writeAdd) begin wa_cnt++; last_wdata = o_data; end
        if (o_rdEn) begin
            if (rd_cnt == 0) rd_first = int'(o_rdAddr);
            rd_last = int'(o_rdAddr);
            rd_cnt++;
        end
        if (!o_avgClr) clr_cnt++;
        if (o_done) done_cnt++;
        if (o_busy) busy_cyc++;
        if (o_resWe) begin
            if (res_cnt < 8) begin res_addr[res_cnt] = o_resAddr; res_data[res_cnt] = o_resData; end
            res_cnt++;
        end
        if (i_reset) begin
            e_busy = 0; e_done = 0; e_clr = 1; e_rden = 0; e_wa = 0; e_we = 0; c = 0; off = 0;
            if (active) begin
                if (rel == CH * CPC) e_done = 1;
                else begin
                    c = rel / CPC;
                    off = rel % CPC;
                    e_busy = 1;
                    e_clr  = (off != 0);
                    e_rden = (off >= 1) && (off <= WPC);
                    e_wa   = (off >= 3) && (off <= WPC + 2);
                    e_we   = (off == CPC - 1);
                end
            end
            chk("busy", o_busy, e_busy);
            chk("done", o_done, e_done);
            chk("avgClr", o_avgClr, e_clr);
            chk("rdEn", o_rdEn, e_rden);
            chk("writeAdd", o_writeAdd, e_wa);
            chk("resWe", o_resWe, e_we);
            if (e_rden) chk("rdAddr", o_rdAddr, c * WPC + off - 1);
            if (e_wa) chk("data", o_data, exp_word(mode, c, off - 3));
            if (e_we) begin
                chk("resAddr", o_resAddr, c);
                chk("resData", o_resData, exp_mean(mode, c));
            end
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_rdEn"}, o_rdEn, 0);
        chk({tag, "_rdAddr"}, o_rdAddr, 0);
        chk({tag, "_avgClr"}, o_avgClr, 1);
        chk({tag, "_writeAdd"}, o_writeAdd, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_resWe"}, o_resWe, 0);
        chk({tag, "_resAddr"}, o_resAddr, 0);
        chk({tag, "_resData"}, o_resData, 0);
    endtask

    task automatic pulse_start();
        @(posedge i_clk); #1 i_start = 1;
        @(posedge i_clk); #1 i_start = 0;
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int n = 0; n < 5000 && !got; n++) begin
            @(negedge i_clk);
            if (o_done) got = 1;
        end
        chk("done_timeout", got, 1);
        repeat (3) @(negedge i_clk);
    endtask

    task automatic wait_rel(input int target);
        bit got;
        got = 0;
        for (int n = 0; n < 5000 && !got; n++) begin
            @(posedge i_clk); #1;
            if (active && rel == target) got = 1;
        end
        chk("rel_timeout", got, 1);
    endtask

    task automatic run(input int md);
        mode = md;
        clear_stats();
        pulse_start();
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        repeat (3) @(negedge i_clk);
        chk_quiet("reset");
        @(posedge i_clk); #1 i_reset = 1;
        repeat (2) @(negedge i_clk);
        chk_quiet("idle");

        // Literal pins on the model itself.
        chk("pin_word8", exp_word(0, 0, WPC - 1), {10'd8, 80'd0});
        chk("pin_mean206", exp_mean(1, 0), 206);
        chk("pin_word3ff", exp_word(3, 0, WPC - 1), {10'h3FF, 80'd0});
        chk("pin_cpc", CPC, 462);

        // Test 1: all lanes 8.
        run(0);
        chk("t1_wa_cnt", wa_cnt, CH * 456);
        chk("t1_last_word", last_wdata, {10'd8, 80'd0});
        chk("t1_res0", {res_addr[0], res_data[0]}, {10'd0, 10'd8});
        chk("t1_done_cnt", done_cnt, 1);

        // Test 2: lane0=255, others 200.
        run(1);
        chk("t2_last_word", last_wdata, {10'd255, 80'd0});
        chk("t2_res0", res_data[0], 206);
        chk("t2_res2", res_data[2], 206);

        // Test 3: last word all 3FF.
        run(3);
        chk("t3_last_word", last_wdata, {10'h3FF, 80'd0});
        chk("t3_res1", res_data[1], 100);

        // Test 4: channel c lanes = c+1.
        run(2);
        chk("t4_rd_cnt", rd_cnt, 1368);
        chk("t4_rd_first", rd_first, 0);
        chk("t4_rd_last", rd_last, 1367);
        chk("t4_clr_cnt", clr_cnt, 3);
        chk("t4_res_cnt", res_cnt, 3);
        chk("t4_res0", {res_addr[0], res_data[0]}, {10'd0, 10'd1});
        chk("t4_res1", {res_addr[1], res_data[1]}, {10'd1, 10'd2});
        chk("t4_res2", {res_addr[2], res_data[2]}, {10'd2, 10'd3});
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_run_cycles", busy_cyc + done_cnt, 3 * 462 + 1);

        // Test 5: reset in the middle of channel 1 FEED.
        mode = 2;
        clear_stats();
        pulse_start();
        wait_rel(CPC + 100);
        i_reset = 0;
        #1 chk_quiet("t5_async");
        repeat (3) @(negedge i_clk);
        chk_quiet("t5_held");
        @(posedge i_clk); #1 i_reset = 1;
        repeat (5) @(negedge i_clk);
        chk("t5_res_cnt", res_cnt, 1);
        chk("t5_done_cnt", done_cnt, 0);
        chk("t5_busy", o_busy, 0);
        run(2);
        chk("t5_rerun_res_cnt", res_cnt, 3);
        chk("t5_rerun_res0", {res_addr[0], res_data[0]}, {10'd0, 10'd1});
        chk("t5_rerun_res2", {res_addr[2], res_data[2]}, {10'd2, 10'd3});

        // Test 6: i_start during FEED and during DONE is ignored.
        mode = 0;
        clear_stats();
        pulse_start();
        wait_rel(200);
        i_start = 1;
        @(posedge i_clk); #1 i_start = 0;
        wait_rel(CH * CPC);
        i_start = 1;
        @(posedge i_clk); #1 i_start = 0;
        repeat (6) @(negedge i_clk);
        chk("t6_busy_after", o_busy, 0);
        chk("t6_rd_cnt", rd_cnt, 1368);
        chk("t6_res_cnt", res_cnt, 3);
        chk("t6_done_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
